// File: rtl/obf_seq.sv
// Sequencer between fetch and decode: holds one reference instruction plus a key
// snapshot for the combinational generator, steps the pseudo PC, and buffers each beat.
module obf_seq #(
  parameter int PPC_WIDTH = 4,
  parameter int KEY_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          ref_insn_i,
  input  logic                 ref_valid_i,
  output logic                 ref_ready_o,
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic                 flush_i,
  output logic [31:0]          gen_ref_insn_o,
  output logic [PPC_WIDTH-1:0] gen_ppc_o,
  output logic [KEY_WIDTH-1:0] gen_key_o,
  input  logic [31:0]          gen_insn_i,
  input  logic                 gen_last_i,
  input  logic                 gen_skip_i,
  output logic [31:0]          out_insn_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 out_first_o,
  output logic                 out_last_o,
  output logic                 out_skip_o,
  output logic                 busy_o,
  output logic                 seq_err_o,
  output logic                 state_dbg_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_e;

  state_e                 state_q;
  logic [PPC_WIDTH-1:0]   ppc_q;
  logic [31:0]            hold_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [31:0]            out_insn_q;
  logic                   out_valid_q;
  logic                   out_first_q;
  logic                   out_last_q;
  logic                   out_skip_q;
  logic                   seq_err_q;

  logic                   slot_free;
  logic                   load;
  logic                   ppc_max;
  logic                   beat_last;
  logic                   seq_end;
  logic                   accept;

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both high. ready may depend combinationally on valid-independent state and on
  // flush_i; valid, once raised, holds its payload stable until the transfer.
  always_comb begin
    slot_free   = !out_valid_q | out_ready_i;
    load        = (state_q == ST_EXPAND) & slot_free & !flush_i;
    ppc_max     = &ppc_q;
    beat_last   = gen_last_i | ppc_max;
    seq_end     = load & beat_last;
    ref_ready_o = rst_n & !flush_i & slot_free & ((state_q == ST_IDLE) | beat_last);
    accept      = ref_valid_i & ref_ready_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ppc_q       <= '0;
      hold_q      <= '0;
      key_q       <= '0;
      out_insn_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_skip_q  <= 1'b0;
      seq_err_q   <= 1'b0;
    end else if (flush_i) begin
      // Abort: drop the slot and the sequence; hold/key regs keep their contents.
      state_q     <= ST_IDLE;
      ppc_q       <= '0;
      out_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      seq_err_q <= 1'b0;
      if (load) begin
        out_insn_q  <= gen_insn_i;
        out_skip_q  <= gen_skip_i;
        out_first_q <= (ppc_q == '0);
        out_last_q  <= beat_last;
        out_valid_q <= 1'b1;
        seq_err_q   <= ppc_max & !gen_last_i;
        if (!beat_last) begin
          ppc_q <= ppc_q + 1'b1;
        end
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end

      if (accept) begin
        hold_q  <= ref_insn_i;
        key_q   <= key_i;
        ppc_q   <= '0;
        state_q <= ST_EXPAND;
      end else if (seq_end) begin
        ppc_q   <= '0;
        state_q <= ST_IDLE;
      end
    end
  end

  assign gen_ref_insn_o = hold_q;
  assign gen_ppc_o      = ppc_q;
  assign gen_key_o      = key_q;
  assign out_insn_o     = out_insn_q;
  assign out_valid_o    = out_valid_q;
  assign out_first_o    = out_first_q;
  assign out_last_o     = out_last_q;
  assign out_skip_o     = out_skip_q;
  assign seq_err_o      = seq_err_q;
  assign busy_o         = (state_q == ST_EXPAND);
  assign state_dbg_o    = state_q;

endmodule
